// File: rtl/infer_ctrl.sv
// rtl/infer_ctrl.sv - inference sequencer: launches the image streamer, waits for scores, reports the argmax.
module infer_ctrl #(
    parameter int NUM_CLASSES    = 10,
    parameter int DW             = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_req,
    output logic                      img_start,
    input  logic                      dout_vld,
    input  logic [NUM_CLASSES*DW-1:0] dout,
    output logic                      busy,
    output logic                      result_vld,
    output logic [3:0]                result_class,
    output logic [DW-1:0]             result_score,
    output logic                      timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_ARGMAX,
        S_REPORT
    } state_t;

    localparam logic [23:0] CNT_LAST = 24'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  IDX_LAST = 4'(NUM_CLASSES - 1);

    state_t                    state_q, state_d;
    logic [23:0]               cnt_q, cnt_d;
    logic [NUM_CLASSES*DW-1:0] data_q, data_d;
    logic [3:0]                idx_q, idx_d;
    logic [3:0]                best_idx_q, best_idx_d;
    logic [DW-1:0]             best_val_q, best_val_d;
    logic [3:0]                res_class_q, res_class_d;
    logic [DW-1:0]             res_score_q, res_score_d;
    logic                      timeout_q, timeout_d;
    logic [DW-1:0]             cur_val;
    logic                      cand_gt;

    // The scan works on the captured copy so dout may change freely during ARGMAX.
    assign cur_val = data_q[idx_q*DW +: DW];
    assign cand_gt = $signed(cur_val) > $signed(best_val_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        idx_d       = idx_q;
        best_idx_d  = best_idx_q;
        best_val_d  = best_val_q;
        res_class_d = res_class_q;
        res_score_d = res_score_q;
        timeout_d   = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (start_req) begin
                    state_d   = S_LAUNCH;
                    timeout_d = 1'b0;
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                if (dout_vld) begin
                    state_d    = S_ARGMAX;
                    data_d     = dout;
                    idx_d      = '0;
                    best_idx_d = '0;
                    best_val_d = dout[DW-1:0];
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            S_ARGMAX: begin
                if (cand_gt) begin
                    best_idx_d = idx_q;
                    best_val_d = cur_val;
                end
                // The last class folds straight into the result registers.
                if (idx_q == IDX_LAST) begin
                    state_d     = S_REPORT;
                    res_class_d = cand_gt ? idx_q : best_idx_q;
                    res_score_d = cand_gt ? cur_val : best_val_q;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            S_REPORT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            data_q      <= '0;
            idx_q       <= '0;
            best_idx_q  <= '0;
            best_val_q  <= '0;
            res_class_q <= '0;
            res_score_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            idx_q       <= idx_d;
            best_idx_q  <= best_idx_d;
            best_val_q  <= best_val_d;
            res_class_q <= res_class_d;
            res_score_q <= res_score_d;
            timeout_q   <= timeout_d;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign img_start    = (state_q == S_LAUNCH);
    assign result_vld   = (state_q == S_REPORT);
    assign result_class = res_class_q;
    assign result_score = res_score_q;
    assign timeout      = timeout_q;

endmodule
